uart_tx: RTL

- UART transmitter; serialises one parallel data word per request onto `tx`.
- Frame format: 1 start bit (0), DBIT data bits LSB first, optional parity bit, stop period (1).
- Bit timing comes from the shared oversampling `s_tick` (16 ticks per bit), the same tick that drives uart_rx.
- Sits between the TX FIFO / interface logic and the pad; loopback-compatible with uart_rx.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and framing constants used by uart_tx
// (and by uart_rx once it migrates here).
package uart_pkg;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned UART_MAX_DBIT = 8;
  localparam int unsigned STATE_W       = 3;

  typedef logic [STATE_W-1:0] uart_state_t;

  localparam uart_state_t IDLE   = 3'd0;
  localparam uart_state_t START  = 3'd1;
  localparam uart_state_t DATA   = 3'd2;
  localparam uart_state_t PARITY = 3'd3;
  localparam uart_state_t STOP   = 3'd4;

  // Tick counter must reach SB_TICK-1 in the stop period (up to 31 for two stop bits).
  function automatic int unsigned tick_cnt_w(input int unsigned sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per accepted tx_start as
// start / DBIT data bits LSB first / optional parity / stop, timed by s_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tick,
  input  logic                     tx_start,
  input  logic [UART_MAX_DBIT-1:0] din,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     tx_done_tick
);

  localparam int unsigned SW = tick_cnt_w(SB_TICK);
  localparam int unsigned NW = 3;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_t     state_reg, state_next;
  logic [SW-1:0]   s_reg,     s_next;
  logic [NW-1:0]   n_reg,     n_next;
  logic [DBIT-1:0] b_reg,     b_next;
  logic            par_reg,   par_next;
  logic            tx_reg,    tx_next;

  // State and datapath registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state and datapath logic; tx_next is the level for the upcoming bit.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din[DBIT-1:0];
          par_next   = PARITY_ODD;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next   = '0;
            par_next = par_reg ^ b_reg[0];
            b_next   = b_reg >> 1;
            if (n_reg == N_LAST) begin
              if (PARITY_EN) begin
                state_next = PARITY;
                tx_next    = par_reg ^ b_reg[0];
              end else begin
                state_next = STOP;
                tx_next    = 1'b1;
              end
            end else begin
              n_next  = n_reg + NW'(1);
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = STOP;
            s_next     = '0;
            tx_next    = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
            s_next     = '0;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Status outputs decoded from registered state; done is Mealy on the final stop tick.
  always_comb begin
    tx_busy      = (state_reg != IDLE);
    tx_done_tick = (state_reg == STOP) && s_tick && (s_reg == S_STOP_LAST);
  end

  assign tx = tx_reg;

endmodule
